// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive and transmit paths.
//   UART_DATA_W      data bits per frame
//   uart_rx_state_t  receiver FSM states (ST_PARITY exists only when
//                    UART_RX_PARITY_EN is defined)
//   uart_div()       rounded clock-cycles-per-bit divider
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_BREAK
    } uart_rx_state_t;

    // round(clk_freq / uart_freq), widened so the rounding add cannot wrap
    function automatic int unsigned uart_div(input int unsigned clk_freq,
                                             input int unsigned uart_freq);
        longint unsigned num;
        num = 64'(clk_freq) + 64'(uart_freq / 2);
        return 32'(num / 64'(uart_freq));
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: byte hand-off and status from the UART receiver.
//   rx_data     received byte, stable while rx_valid is high
//   rx_valid    holding register occupied
//   rx_ready    consumer accepts the byte when rx_valid && rx_ready
//   rx_busy     frame in progress
//   frame_err   one-cycle pulse, stop bit sampled low
//   overrun_err one-cycle pulse, good byte dropped (holding register full)
//   parity_err  one-cycle pulse, parity mismatch (0 in the 8N1 build)
// master: the receiver; slave: the consumer.
interface uart_rx_if;
    import uart_pkg::*;

    logic [UART_DATA_W-1:0] rx_data;
    logic                   rx_valid;
    logic                   rx_ready;
    logic                   rx_busy;
    logic                   frame_err;
    logic                   overrun_err;
    logic                   parity_err;

    modport master (
        output rx_data, rx_valid, rx_busy, frame_err, overrun_err, parity_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, rx_busy, frame_err, overrun_err, parity_err,
        output rx_ready
    );

endinterface

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: loadable down-counter that saturates at zero.
//   clk, rst_n   clock, asynchronous active-low reset
//   load_i       load load_val_i this cycle (takes priority over counting)
//   load_val_i   value to load
//   expire_o     high in the cycle the count steps from 1 to 0, so a load
//                of N expires N-1 cycles after the load cycle + 1, i.e. N
//                cycles after the cycle that asserted load_i
module uart_baud_cnt #(
    parameter int unsigned W = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == W'(1));

endmodule

// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver, 8 data bits LSB first, 1 stop bit,
// one-entry valid/ready holding register.
//   clk_freq, uart_freq  clock frequency and baud rate in Hz / bit/s
//   clk, rst_n           system clock, asynchronous active-low reset
//   rxp                  serial line, idles high, asynchronous to clk
//   rx_if (master)       byte hand-off, busy and error pulses (uart_rx_if)
// Build option: define UART_RX_PARITY_EN for 8E1 frames with a live
// parity_err; otherwise frames are 8N1 and parity_err is tied low.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned clk_freq  = 133333000,
    parameter int unsigned uart_freq = 115200
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rxp,
    uart_rx_if.master rx_if
);

    localparam int unsigned DIV   = uart_div(clk_freq, uart_freq);
    localparam int unsigned HALF  = DIV / 2;
    localparam int unsigned CNT_W = $clog2(DIV + 1);

    if (DIV < 4) begin : g_bad_div
        $error("uart_rx: clk_freq/uart_freq yields a divider below 4");
    end

    uart_rx_state_t               state_q, state_d;
    logic [1:0]                   sync_q;
    logic [2:0]                   hist_q;
    logic [2:0]                   bit_idx_q, bit_idx_d;
    logic [UART_DATA_W-1:0]       shift_q, shift_d;
    logic [UART_DATA_W-1:0]       rx_data_q, rx_data_d;
    logic                         rx_valid_q, rx_valid_d;
    logic                         frame_err_q, frame_err_d;
    logic                         overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
    logic                         par_bad_q, par_bad_d;
    logic                         parity_err_q, parity_err_d;
`endif

    logic                         rxs;
    logic                         vote;
    logic                         fall;
    logic                         deliver;
    logic                         cnt_load;
    logic [CNT_W-1:0]             cnt_val;
    logic                         expire;

    assign rxs  = sync_q[1];
    assign vote = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) |
                  (hist_q[1] & hist_q[2]);
    // hist_q[0] is last cycle's rxs, so this is a 1->0 transition on rxs
    assign fall = hist_q[0] & ~rxs;

    uart_baud_cnt #(.W(CNT_W)) u_baud_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .expire_o   (expire)
    );

    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        cnt_load    = 1'b0;
        cnt_val     = CNT_W'(DIV);
        deliver     = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        if (rx_valid_q && rx_if.rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(HALF);
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (expire) begin
                    if (vote) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_load  = 1'b1;
                        bit_idx_d = '0;
                        state_d   = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (expire) begin
                    shift_d[bit_idx_q] = vote;
                    cnt_load           = 1'b1;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (expire) begin
                    par_bad_d = vote ^ (^shift_q);
                    cnt_load  = 1'b1;
                    state_d   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (expire) begin
                    if (!vote) begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad_q) begin
                        parity_err_d = 1'b1;
                        state_d      = ST_IDLE;
`endif
                    end else begin
                        deliver = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_BREAK: begin
                if (rxs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // a byte may load in the same cycle the consumer takes the old one
        if (deliver) begin
            if (!rx_valid_q || rx_if.rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sync_q       <= '1;
            hist_q       <= '1;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sync_q       <= {sync_q[0], rxp};
            hist_q       <= {hist_q[1:0], rxs};
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_if.rx_data     = rx_data_q;
    assign rx_if.rx_valid    = rx_valid_q;
    assign rx_if.rx_busy     = (state_q != ST_IDLE);
    assign rx_if.frame_err   = frame_err_q;
    assign rx_if.overrun_err = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign rx_if.parity_err  = parity_err_q;
`else
    assign rx_if.parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

    // default instance: 133333000/115200 -> DIV 1157, HALF 578
    localparam int DIV_B  = 1157;
    localparam int HALF_B = 578;
    // small instance: 6400000/100000 -> DIV 64, HALF 32
    localparam int DIV_S  = 64;
    localparam int HALF_S = 32;
`ifdef UART_RX_PARITY_EN
    localparam int NFRAME = 11;
`else
    localparam int NFRAME = 10;
`endif
    // cycles from the pin falling edge to the cycle the result is visible
    localparam int LAT_B = 3 + HALF_B + (NFRAME - 1) * DIV_B;
    localparam int LAT_S = 3 + HALF_S + (NFRAME - 1) * DIV_S;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rxp_s = 1'b1;
    logic rxp_b = 1'b1;

    uart_rx_if if_s();
    uart_rx_if if_b();

    uart_rx #(.clk_freq(6_400_000), .uart_freq(100_000)) u_dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .rxp   (rxp_s),
        .rx_if (if_s)
    );

    uart_rx u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .rxp   (rxp_b),
        .rx_if (if_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fe_s = 0, ov_s = 0, pe_s = 0, fe_b = 0, ov_b = 0;
    int fe_cyc = 0, ov_cyc = 0;
    logic [7:0] got_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (if_s.frame_err === 1'b1) begin
            fe_s   <= fe_s + 1;
            fe_cyc <= cyc;
        end
        if (if_s.overrun_err === 1'b1) begin
            ov_s   <= ov_s + 1;
            ov_cyc <= cyc;
        end
        if (if_s.parity_err === 1'b1) pe_s <= pe_s + 1;
        if (if_b.frame_err === 1'b1) fe_b <= fe_b + 1;
        if (if_b.overrun_err === 1'b1) ov_b <= ov_b + 1;
        if (if_s.rx_valid === 1'b1 && if_s.rx_ready === 1'b1) got_q.push_back(if_s.rx_data);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pop_byte();
        if (got_q.size() == 0) return 32'hFFFF_FFFF;
        return {24'h0, got_q.pop_front()};
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit big, input logic v);
        if (big) rxp_b = v;
        else     rxp_s = v;
    endtask

    // spike_at: frame bit index (0 = start) that gets a one-cycle inverted
    // spike placed inside the receiver's vote window; -1 for none
    task automatic send_frame(input bit big, input logic [7:0] b, input logic stop_v,
                              input logic par_good, input int spike_at);
        logic [10:0] bits;
        int div;
        div = big ? DIV_B : DIV_S;
`ifdef UART_RX_PARITY_EN
        bits = {stop_v, (^b) ^ ~par_good, b, 1'b0};
`else
        bits = {1'b0, stop_v, b, 1'b0};
`endif
        for (int j = 0; j < NFRAME; j++) begin
            drive(big, bits[j]);
            if (j == spike_at) begin
                wait_cyc(div / 2 - 2);
                drive(big, ~bits[j]);
                wait_cyc(1);
                drive(big, bits[j]);
                wait_cyc(div - div / 2 + 1);
            end else begin
                wait_cyc(div);
            end
        end
    endtask

    initial begin
        int lat;
        int c0;

        if_s.rx_ready = 1'b1;
        if_b.rx_ready = 1'b0;

        // reset values, checked while reset is held
        wait_cyc(4);
        chk("rst_data", if_s.rx_data, 32'h00);
        chk("rst_valid", if_s.rx_valid, 32'h0);
        chk("rst_busy", if_s.rx_busy, 32'h0);
        chk("rst_ferr", if_s.frame_err, 32'h0);
        chk("rst_oerr", if_s.overrun_err, 32'h0);
        chk("rst_perr", if_s.parity_err, 32'h0);
        rst_n = 1'b1;
        wait_cyc(4);

        // 0x55 on the default instance, exact latency from pin to rx_valid
        lat = 0;
        fork
            send_frame(1'b1, 8'h55, 1'b1, 1'b1, -1);
            begin
                while (if_b.rx_valid !== 1'b1 && lat < 12 * DIV_B) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
            end
        join
        chk("lat_55", lat, LAT_B);
        chk("data_55", if_b.rx_data, 32'h55);
        chk("err_55", fe_b + ov_b, 0);

        // 200-cycle low glitch on the default instance
        drive(1'b1, 1'b0);
        wait_cyc(100);
        chk("glitch_busy", if_b.rx_busy, 32'h1);
        wait_cyc(100);
        drive(1'b1, 1'b1);
        wait_cyc(HALF_B + 50);
        chk("glitch_idle", if_b.rx_busy, 32'h0);
        chk("glitch_data", if_b.rx_data, 32'h55);
        chk("glitch_valid", if_b.rx_valid, 32'h1);
        chk("glitch_err", fe_b + ov_b, 0);

        // back-to-back frames with rx_ready high
        send_frame(1'b0, 8'h00, 1'b1, 1'b1, -1);
        send_frame(1'b0, 8'hFF, 1'b1, 1'b1, -1);
        send_frame(1'b0, 8'hA5, 1'b1, 1'b1, -1);
        wait_cyc(DIV_S);
        chk("b2b_count", got_q.size(), 3);
        chk("b2b_0", pop_byte(), 32'h00);
        chk("b2b_1", pop_byte(), 32'hFF);
        chk("b2b_2", pop_byte(), 32'hA5);
        chk("b2b_err", fe_s + ov_s + pe_s, 0);

        // stop bit low, line held low 20 bit times, then 0x3C
        c0 = cyc;
        send_frame(1'b0, 8'h81, 1'b0, 1'b1, -1);
        wait_cyc(20 * DIV_S);
        chk("ferr_count", fe_s, 1);
        chk("ferr_time", fe_cyc - c0, LAT_S);
        chk("ferr_nobyte", got_q.size(), 0);
        chk("ferr_break_busy", if_s.rx_busy, 32'h1);
        drive(1'b0, 1'b1);
        wait_cyc(2 * DIV_S);
        chk("ferr_idle", if_s.rx_busy, 32'h0);
        send_frame(1'b0, 8'h3C, 1'b1, 1'b1, -1);
        wait_cyc(DIV_S);
        chk("after_ferr", pop_byte(), 32'h3C);
        chk("ferr_once", fe_s, 1);

        // holding register full: 0x22 overruns, 0x11 kept
        if_s.rx_ready = 1'b0;
        send_frame(1'b0, 8'h11, 1'b1, 1'b1, -1);
        c0 = cyc;
        send_frame(1'b0, 8'h22, 1'b1, 1'b1, -1);
        wait_cyc(DIV_S);
        chk("ovr_valid", if_s.rx_valid, 32'h1);
        chk("ovr_data", if_s.rx_data, 32'h11);
        chk("ovr_count", ov_s, 1);
        chk("ovr_time", ov_cyc - c0, LAT_S);
        if_s.rx_ready = 1'b1;
        wait_cyc(2);
        chk("ovr_drain", if_s.rx_valid, 32'h0);
        chk("ovr_pop", pop_byte(), 32'h11);

        // single-cycle spike at the center of data bit 2
        send_frame(1'b0, 8'hC3, 1'b1, 1'b1, 3);
        wait_cyc(DIV_S);
        chk("spike_data", pop_byte(), 32'hC3);

        // reset pulsed at bit 4 of 0xF0, then a clean 0x5A
        drive(1'b0, 1'b0);
        wait_cyc(5 * DIV_S);
        drive(1'b0, 1'b1);
        wait_cyc(HALF_S);
        chk("midrst_busy", if_s.rx_busy, 32'h1);
        rst_n = 1'b0;
        wait_cyc(2);
        chk("midrst_abort", if_s.rx_busy, 32'h0);
        rst_n = 1'b1;
        wait_cyc(5 * DIV_S);
        chk("midrst_idle", if_s.rx_busy, 32'h0);
        chk("midrst_nobyte", got_q.size(), 0);
        chk("midrst_noerr", fe_s + ov_s + pe_s, 2);
        send_frame(1'b0, 8'h5A, 1'b1, 1'b1, -1);
        wait_cyc(DIV_S);
        chk("midrst_next", pop_byte(), 32'h5A);

`ifdef UART_RX_PARITY_EN
        send_frame(1'b0, 8'h07, 1'b1, 1'b0, -1);
        wait_cyc(DIV_S);
        chk("par_bad_pulse", pe_s, 1);
        chk("par_bad_nobyte", got_q.size(), 0);
        chk("par_bad_valid", if_s.rx_valid, 32'h0);
        send_frame(1'b0, 8'h07, 1'b1, 1'b1, -1);
        wait_cyc(DIV_S);
        chk("par_good", pop_byte(), 32'h07);
        chk("par_good_once", pe_s, 1);
`else
        chk("par_tied", pe_s, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
